// File: rtl/analyzer_mem_pkg.sv
// Shared definitions for the analyzer sample-memory path: arbiter state
// encoding, packet-to-word geometry and the sample-number to word-address
// conversion that the capture writer also uses.
package analyzer_mem_pkg;

    // Arbiter command-port states.
    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_ISSUE     = 2'd1,
        ST_WAIT_DONE = 2'd2
    } arb_state_e;

    // Memory words occupied by one stored sample packet.
    function automatic int unsigned calc_words_per_packet(
        input int unsigned packet_bits,
        input int unsigned word_bytes
    );
        return (packet_bits / 32'd8) / word_bytes;
    endfunction

    // Default geometry of the analyzer build.
    localparam int unsigned SAMPLE_PACKET_WIDTH_DEF = 32'd32;
    localparam int unsigned MEMORY_WORD_WIDTH_DEF   = 32'd2;
    localparam int unsigned WORDS_PER_PACKET =
        calc_words_per_packet(SAMPLE_PACKET_WIDTH_DEF, MEMORY_WORD_WIDTH_DEF);

    // Full-width word offset of a sample; callers truncate to their address
    // width, which makes addresses beyond capacity wrap around the memory.
    function automatic logic [63:0] sample_to_word(
        input logic [31:0] sample_number,
        input int unsigned words_per_packet
    );
        return {32'd0, sample_number} * 64'(words_per_packet);
    endfunction

endpackage

// File: rtl/analyzer_mem_arbiter.sv
// Arbitrates the single sample-memory command port between the capture
// write path (priority) and the trace readback path (starvation-protected).
// One burst is outstanding at a time: IDLE selects, ISSUE holds the command
// until the controller accepts it, WAIT_DONE waits for burst completion.
module analyzer_mem_arbiter
    import analyzer_mem_pkg::*;
#(
    parameter int unsigned SAMPLE_PACKET_WIDTH = 32'd32,
    parameter int unsigned MEMORY_WORD_WIDTH   = 32'd2,
    parameter int unsigned ADDR_WIDTH          = 32'd27,
    parameter int unsigned BURST_PACKETS       = 32'd4,
    parameter int unsigned RD_STARVE_LIMIT     = 32'd8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  wr_req,
    input  logic [31:0]           wr_sample_number,
    output logic                  wr_grant,
    input  logic                  rd_req,
    input  logic [31:0]           rd_sample_number,
    input  logic                  rd_fifo_ready,
    output logic                  rd_grant,
    output logic                  mem_cmd_valid,
    input  logic                  mem_cmd_ready,
    output logic                  mem_cmd_write,
    output logic [ADDR_WIDTH-1:0] mem_cmd_addr,
    input  logic                  mem_done,
    output logic                  busy,
    output logic                  protocol_err
);

    localparam int unsigned LP_WORDS_PER_PACKET =
        calc_words_per_packet(SAMPLE_PACKET_WIDTH, MEMORY_WORD_WIDTH);
    localparam logic [7:0] LP_STARVE_LIMIT = 8'(RD_STARVE_LIMIT);

    arb_state_e            r_state;
    logic [7:0]            r_starve_cnt;
    logic                  r_cmd_valid;
    logic                  r_cmd_write;
    logic [ADDR_WIDTH-1:0] r_cmd_addr;
    logic                  r_busy;
    logic                  r_protocol_err;

    logic                  w_rd_elig;
    logic                  w_sel_rd;
    logic                  w_sel_wr;
    logic                  w_handshake;
    logic [ADDR_WIDTH-1:0] w_wr_addr;
    logic [ADDR_WIDTH-1:0] w_rd_addr;
    logic [7:0]            w_starve_next;

    // Selection decision and candidate addresses for the IDLE cycle.
    always_comb begin
        w_rd_elig   = rd_req & rd_fifo_ready;
        w_sel_rd    = 1'b0;
        w_sel_wr    = 1'b0;
        w_handshake = r_cmd_valid & mem_cmd_ready;
        w_wr_addr   = ADDR_WIDTH'(sample_to_word(wr_sample_number, LP_WORDS_PER_PACKET));
        w_rd_addr   = ADDR_WIDTH'(sample_to_word(rd_sample_number, LP_WORDS_PER_PACKET));
        if (w_rd_elig && (!wr_req || (r_starve_cnt == LP_STARVE_LIMIT))) begin
            w_sel_rd = 1'b1;
        end else if (wr_req) begin
            w_sel_wr = 1'b1;
        end else begin
            w_sel_rd = 1'b0;
            w_sel_wr = 1'b0;
        end
    end

    // Starvation count after a write selection: count writes that pass over
    // an eligible read, restart whenever no read was waiting.
    always_comb begin
        w_starve_next = 8'd0;
        if (w_rd_elig) begin
            if (r_starve_cnt < LP_STARVE_LIMIT) begin
                w_starve_next = r_starve_cnt + 8'd1;
            end else begin
                w_starve_next = LP_STARVE_LIMIT;
            end
        end else begin
            w_starve_next = 8'd0;
        end
    end

    // Command-port FSM with registered command, busy and error outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state        <= ST_IDLE;
            r_starve_cnt   <= 8'd0;
            r_cmd_valid    <= 1'b0;
            r_cmd_write    <= 1'b0;
            r_cmd_addr     <= '0;
            r_busy         <= 1'b0;
            r_protocol_err <= 1'b0;
        end else begin
            // A completion outside WAIT_DONE never belongs to our burst.
            if (mem_done && (r_state != ST_WAIT_DONE)) begin
                r_protocol_err <= 1'b1;
            end

            case (r_state)
                ST_IDLE: begin
                    if (w_sel_rd) begin
                        r_cmd_write  <= 1'b0;
                        r_cmd_addr   <= w_rd_addr;
                        r_cmd_valid  <= 1'b1;
                        r_busy       <= 1'b1;
                        r_starve_cnt <= 8'd0;
                        r_state      <= ST_ISSUE;
                    end else if (w_sel_wr) begin
                        r_cmd_write  <= 1'b1;
                        r_cmd_addr   <= w_wr_addr;
                        r_cmd_valid  <= 1'b1;
                        r_busy       <= 1'b1;
                        r_starve_cnt <= w_starve_next;
                        r_state      <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    // Command fields stay latched until the controller takes them.
                    if (w_handshake) begin
                        r_cmd_valid <= 1'b0;
                        r_state     <= ST_WAIT_DONE;
                    end
                end
                ST_WAIT_DONE: begin
                    if (mem_done) begin
                        r_busy  <= 1'b0;
                        r_state <= ST_IDLE;
                    end
                end
                default: begin
                    r_cmd_valid <= 1'b0;
                    r_busy      <= 1'b0;
                    r_state     <= ST_IDLE;
                end
            endcase
        end
    end

    // Grants mark the accepting handshake cycle, so they follow mem_cmd_ready
    // directly; only one command is ever valid, so they cannot coincide.
    assign wr_grant      = w_handshake & r_cmd_write;
    assign rd_grant      = w_handshake & ~r_cmd_write;
    assign mem_cmd_valid = r_cmd_valid;
    assign mem_cmd_write = r_cmd_write;
    assign mem_cmd_addr  = r_cmd_addr;
    assign busy          = r_busy;
    assign protocol_err  = r_protocol_err;

endmodule

// File: tb/tb_analyzer_mem_arbiter.sv
// Self-checking bench for analyzer_mem_arbiter: directed scenarios plus a
// randomized run, against a transaction-level reference of the arbitration
// rules kept in the bench.
module tb_analyzer_mem_arbiter;

    localparam int AW    = 27;
    localparam int LIMIT = 8;
    localparam int WPP   = 32 / 8 / 2;

    logic          clk = 1'b0;
    logic          reset;
    logic          wr_req;
    logic [31:0]   wr_sample_number;
    logic          wr_grant;
    logic          rd_req;
    logic [31:0]   rd_sample_number;
    logic          rd_fifo_ready;
    logic          rd_grant;
    logic          mem_cmd_valid;
    logic          mem_cmd_ready;
    logic          mem_cmd_write;
    logic [AW-1:0] mem_cmd_addr;
    logic          mem_done;
    logic          busy;
    logic          protocol_err;

    int n_vec = 0;
    int n_err = 0;
    int model_passed_reads = 0;

    analyzer_mem_arbiter dut (
        .clk              (clk),
        .reset            (reset),
        .wr_req           (wr_req),
        .wr_sample_number (wr_sample_number),
        .wr_grant         (wr_grant),
        .rd_req           (rd_req),
        .rd_sample_number (rd_sample_number),
        .rd_fifo_ready    (rd_fifo_ready),
        .rd_grant         (rd_grant),
        .mem_cmd_valid    (mem_cmd_valid),
        .mem_cmd_ready    (mem_cmd_ready),
        .mem_cmd_write    (mem_cmd_write),
        .mem_cmd_addr     (mem_cmd_addr),
        .mem_done         (mem_done),
        .busy             (busy),
        .protocol_err     (protocol_err)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    // Word address of a sample: packet index times words per packet, modulo memory size.
    function automatic logic [AW-1:0] ref_addr(input logic [31:0] s);
        longint p;
        p = (longint'(s) * WPP) % (longint'(1) << AW);
        return AW'(p);
    endfunction

    // Reference arbitration: returns 1 for write. Writes win unless a read is
    // eligible and has already been passed over LIMIT times in a row.
    function automatic bit model_pick(input bit wr, input bit elig);
        bit pick_wr;
        pick_wr = wr && !(elig && model_passed_reads >= LIMIT);
        if (!elig) model_passed_reads = 0;
        else if (!pick_wr) model_passed_reads = 0;
        else if (model_passed_reads < LIMIT) model_passed_reads = model_passed_reads + 1;
        return pick_wr;
    endfunction

    // One full burst, started from an IDLE cycle whose requests are already driven.
    task automatic do_burst(input string name, input bit exp_wr, input logic [AW-1:0] exp_addr,
                            input int rdy_dly, input int done_dly);
        int grants;
        grants = 0;
        mem_cmd_ready = 1'b0;
        step();
        for (int c = 0; c <= rdy_dly; c++) begin
            mem_cmd_ready = (c == rdy_dly);
            #1;
            n_vec++;
            if (mem_cmd_valid !== 1'b1 || mem_cmd_write !== exp_wr || mem_cmd_addr !== exp_addr || busy !== 1'b1) begin
                n_err++;
                $display("FAIL %s issue c%0d: valid=%b wr=%b addr=%h busy=%b, expected 1 %b %h 1",
                         name, c, mem_cmd_valid, mem_cmd_write, mem_cmd_addr, busy, exp_wr, exp_addr);
            end
            n_vec++;
            if (wr_grant !== ((c == rdy_dly) && exp_wr) || rd_grant !== ((c == rdy_dly) && !exp_wr)) begin
                n_err++;
                $display("FAIL %s grant c%0d: wr_grant=%b rd_grant=%b, expected %b %b",
                         name, c, wr_grant, rd_grant, (c == rdy_dly) && exp_wr, (c == rdy_dly) && !exp_wr);
            end
            grants += int'(wr_grant) + int'(rd_grant);
            if (c < rdy_dly) step();
        end
        step();
        mem_cmd_ready = 1'b0;
        for (int d = 0; d <= done_dly; d++) begin
            mem_done = (d == done_dly);
            #1;
            n_vec++;
            if (mem_cmd_valid !== 1'b0 || busy !== 1'b1 || wr_grant !== 1'b0 || rd_grant !== 1'b0) begin
                n_err++;
                $display("FAIL %s wait d%0d: valid=%b busy=%b grants=%b%b, expected 0 1 00",
                         name, d, mem_cmd_valid, busy, wr_grant, rd_grant);
            end
            grants += int'(wr_grant) + int'(rd_grant);
            step();
        end
        mem_done = 1'b0;
        #1;
        n_vec++;
        if (busy !== 1'b0 || mem_cmd_valid !== 1'b0 || grants != 1) begin
            n_err++;
            $display("FAIL %s end: busy=%b valid=%b grants=%0d, expected 0 0 1",
                     name, busy, mem_cmd_valid, grants);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; wr_req = 1'b0; rd_req = 1'b0; rd_fifo_ready = 1'b0;
        wr_sample_number = 32'd0; rd_sample_number = 32'd0;
        mem_cmd_ready = 1'b0; mem_done = 1'b1;
        step();
        step();
        mem_done = 1'b0;
        #1;
        n_vec++;
        if ({mem_cmd_valid, mem_cmd_write, wr_grant, rd_grant, busy, protocol_err} !== 6'b0 || mem_cmd_addr !== '0) begin
            n_err++;
            $display("FAIL reset outputs: v=%b w=%b wg=%b rg=%b busy=%b perr=%b addr=%h, expected all 0",
                     mem_cmd_valid, mem_cmd_write, wr_grant, rd_grant, busy, protocol_err, mem_cmd_addr);
        end
        reset = 1'b0;
        model_passed_reads = 0;
        step();
        n_vec++;
        if (busy !== 1'b0 || mem_cmd_valid !== 1'b0) begin
            n_err++;
            $display("FAIL reset idle: busy=%b valid=%b, expected 0 0", busy, mem_cmd_valid);
        end
    endtask

    task automatic test_write_only();
        wr_req = 1'b1; wr_sample_number = 32'h10;
        void'(model_pick(1'b1, 1'b0));
        do_burst("write_only", 1'b1, 27'h20, 0, 2);
        wr_req = 1'b0;
        step();
        n_vec++;
        if (busy !== 1'b0 || mem_cmd_valid !== 1'b0) begin
            n_err++;
            $display("FAIL write_only idle: busy=%b valid=%b, expected 0 0", busy, mem_cmd_valid);
        end
    endtask

    task automatic test_read_truncation();
        rd_req = 1'b1; rd_fifo_ready = 1'b1; rd_sample_number = 32'h07FF_FFFF;
        void'(model_pick(1'b0, 1'b1));
        do_burst("read_trunc", 1'b0, 27'h7FF_FFFE, 0, 1);
        rd_req = 1'b0;
    endtask

    task automatic test_starvation();
        bit exp_wr;
        wr_req = 1'b1; rd_req = 1'b1; rd_fifo_ready = 1'b1;
        for (int i = 0; i < 27; i++) begin
            wr_sample_number = $urandom;
            rd_sample_number = $urandom;
            exp_wr = ((i % 9) != 8);
            void'(model_pick(1'b1, 1'b1));
            do_burst("starve", exp_wr, exp_wr ? ref_addr(wr_sample_number) : ref_addr(rd_sample_number), 0, 0);
        end
        wr_req = 1'b0; rd_req = 1'b0;
    endtask

    task automatic test_fifo_not_ready();
        wr_req = 1'b1; rd_req = 1'b1; rd_fifo_ready = 1'b0;
        for (int i = 0; i < 10; i++) begin
            wr_sample_number = $urandom;
            void'(model_pick(1'b1, 1'b0));
            do_burst("fifo_not_ready", 1'b1, ref_addr(wr_sample_number), 0, 0);
        end
        wr_req = 1'b0; rd_fifo_ready = 1'b1; rd_sample_number = 32'h123;
        void'(model_pick(1'b0, 1'b1));
        do_burst("fifo_ready_read", 1'b0, ref_addr(32'h123), 0, 0);
        // Counter must have stayed clear: a fresh mix again yields LIMIT writes first.
        wr_req = 1'b1;
        for (int i = 0; i <= LIMIT; i++) begin
            wr_sample_number = $urandom;
            rd_sample_number = $urandom;
            void'(model_pick(1'b1, 1'b1));
            do_burst("after_clear", i < LIMIT, (i < LIMIT) ? ref_addr(wr_sample_number) : ref_addr(rd_sample_number), 0, 0);
        end
        wr_req = 1'b0; rd_req = 1'b0;
    endtask

    task automatic test_ready_stall();
        wr_req = 1'b1; wr_sample_number = 32'h0ABC_DEF1;
        void'(model_pick(1'b1, 1'b0));
        do_burst("ready_stall", 1'b1, ref_addr(32'h0ABC_DEF1), 5, 1);
        wr_req = 1'b0;
        rd_req = 1'b1; rd_fifo_ready = 1'b1; rd_sample_number = 32'h4444_0001;
        void'(model_pick(1'b0, 1'b1));
        do_burst("ready_stall_rd", 1'b0, ref_addr(32'h4444_0001), 5, 0);
        rd_req = 1'b0;
    endtask

    task automatic test_random();
        bit w;
        bit r;
        bit f;
        bit exp_wr;
        for (int i = 0; i < 60; i++) begin
            w = 1'($urandom_range(0, 1));
            r = 1'($urandom_range(0, 1));
            f = 1'($urandom_range(0, 1));
            wr_req = w; rd_req = r; rd_fifo_ready = f;
            wr_sample_number = $urandom;
            rd_sample_number = $urandom;
            if (!w && !(r && f)) begin
                step();
                n_vec++;
                if (mem_cmd_valid !== 1'b0 || busy !== 1'b0) begin
                    n_err++;
                    $display("FAIL random idle %0d: valid=%b busy=%b, expected 0 0", i, mem_cmd_valid, busy);
                end
            end else begin
                exp_wr = model_pick(w, r && f);
                do_burst("random", exp_wr, exp_wr ? ref_addr(wr_sample_number) : ref_addr(rd_sample_number),
                         $urandom_range(0, 3), $urandom_range(0, 3));
            end
        end
        wr_req = 1'b0; rd_req = 1'b0; rd_fifo_ready = 1'b0;
        #1;
        n_vec++;
        if (protocol_err !== 1'b0) begin
            n_err++;
            $display("FAIL random protocol_err=%b, expected 0", protocol_err);
        end
    endtask

    task automatic test_reset_mid_burst();
        wr_req = 1'b1; wr_sample_number = 32'h55;
        mem_cmd_ready = 1'b1;
        step();
        step();
        mem_cmd_ready = 1'b0; wr_req = 1'b0;
        #1;
        n_vec++;
        if (busy !== 1'b1 || mem_cmd_valid !== 1'b0) begin
            n_err++;
            $display("FAIL mid_burst setup: busy=%b valid=%b, expected 1 0", busy, mem_cmd_valid);
        end
        reset = 1'b1;
        step();
        reset = 1'b0;
        model_passed_reads = 0;
        #1;
        n_vec++;
        if ({mem_cmd_valid, mem_cmd_write, wr_grant, rd_grant, busy, protocol_err} !== 6'b0 || mem_cmd_addr !== '0) begin
            n_err++;
            $display("FAIL mid_burst reset: v=%b w=%b wg=%b rg=%b busy=%b perr=%b addr=%h, expected all 0",
                     mem_cmd_valid, mem_cmd_write, wr_grant, rd_grant, busy, protocol_err, mem_cmd_addr);
        end
        step();
        mem_done = 1'b1;
        step();
        mem_done = 1'b0;
        #1;
        n_vec++;
        if (protocol_err !== 1'b1 || busy !== 1'b0 || mem_cmd_valid !== 1'b0) begin
            n_err++;
            $display("FAIL stray_done: perr=%b busy=%b valid=%b, expected 1 0 0", protocol_err, busy, mem_cmd_valid);
        end
        // The arbiter keeps working with the sticky flag set.
        rd_req = 1'b1; rd_fifo_ready = 1'b1; rd_sample_number = 32'h9;
        void'(model_pick(1'b0, 1'b1));
        do_burst("after_stray", 1'b0, ref_addr(32'h9), 0, 0);
        rd_req = 1'b0;
        n_vec++;
        if (protocol_err !== 1'b1) begin
            n_err++;
            $display("FAIL sticky perr=%b, expected 1", protocol_err);
        end
    endtask

    initial begin
        test_reset();
        test_write_only();
        test_read_truncation();
        test_starvation();
        test_fifo_not_ready();
        test_ready_stall();
        test_random();
        test_reset_mid_burst();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
